cosine_sim_requester: RTL and testbench

- Initiator side of the cosine-similarity start/done handshake.
- Holds a query vector and a small candidate buffer, issues one similarity job per candidate to a `cosine_similarity_unit` instance, and captures each result.
- Tracks the best (maximum) FP16 similarity and its candidate index, then returns one result per request over a valid/ready interface.
- Sits between the token-matching logic and the similarity datapath.

---
 rtl/cossim_pkg.sv | 27 ++
 rtl/fp16_gt.sv | 27 ++
 rtl/cosine_sim_requester.sv | 169 ++++++++++++++++
 tb/tb_cosine_sim_requester.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cossim_pkg.sv
// Shared types and constants for the cosine-similarity requester slice.
package cossim_pkg;

  localparam int VEC_LEN = 32;

  typedef logic [15:0] fp16_t;
  typedef fp16_t [VEC_LEN-1:0] fp16_vec_t;

  localparam fp16_t FP16_ZERO    = 16'h0000;
  localparam fp16_t FP16_ONE     = 16'h3C00;
  localparam fp16_t FP16_NEG_ONE = 16'hBC00;
  localparam fp16_t FP16_QNAN    = 16'h7E00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_UPDATE,
    ST_RESP
  } req_state_e;

  // All-ones exponent with a non-zero mantissa is a NaN; infinities are ordinary values.
  function automatic logic fp16_is_nan(input fp16_t x);
    return (x[14:10] == 5'h1F) && (x[9:0] != 10'h000);
  endfunction

endpackage

// File: rtl/fp16_gt.sv
// Strict FP16 greater-than: a > b, false whenever either side is NaN.
// Sign-magnitude is mapped to an unsigned ordered key; +0 and -0 compare equal.
module fp16_gt
  import cossim_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        gt,
  output logic        a_nan
);

  logic        b_nan;
  logic        both_zero;
  logic [15:0] key_a;
  logic [15:0] key_b;

  // Negative values flip their magnitude so larger magnitudes sort lower; positives sit above.
  always_comb begin
    a_nan     = fp16_is_nan(a);
    b_nan     = fp16_is_nan(b);
    both_zero = (a[14:0] == 15'h0000) && (b[14:0] == 15'h0000);
    key_a     = a[15] ? {1'b0, ~a[14:0]} : {1'b1, a[14:0]};
    key_b     = b[15] ? {1'b0, ~b[14:0]} : {1'b1, b[14:0]};
    gt        = !a_nan && !b_nan && !both_zero && (key_a > key_b);
  end

endmodule

// File: rtl/cosine_sim_requester.sv
// Scans a small candidate buffer against one query through the similarity unit,
// one start/done job per candidate, and returns the best-scoring candidate.
module cosine_sim_requester
  import cossim_pkg::*;
#(
  parameter int VEC_LEN  = 32,
  parameter int NUM_CAND = 8,
  parameter int TIMEOUT  = 64,
  parameter int IDX_W    = $clog2(NUM_CAND)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cand_we,
  input  logic [IDX_W-1:0]       cand_idx,
  input  logic [16*VEC_LEN-1:0]  cand_vec,
  input  logic [15:0]            cand_mag_inv,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [16*VEC_LEN-1:0]  req_vec,
  input  logic [15:0]            req_mag_inv,
  input  logic [IDX_W:0]         req_num_cand,
  output logic                   cs_start,
  input  logic                   cs_done,
  output logic [16*VEC_LEN-1:0]  cs_vec1,
  output logic [16*VEC_LEN-1:0]  cs_vec2,
  output logic [15:0]            cs_vec1_mag_inv,
  output logic [15:0]            cs_vec2_mag_inv,
  input  logic [15:0]            cs_similarity,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [IDX_W-1:0]       res_best_idx,
  output logic [15:0]            res_best_sim,
  output logic                   res_none,
  output logic                   res_timeout,
  output logic                   busy
);

  localparam int              VW           = 16 * VEC_LEN;
  localparam int              WCNT_W       = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W:0]  NUM_CAND_C   = (IDX_W+1)'(NUM_CAND);
  localparam logic [IDX_W:0]  ONE_N        = (IDX_W+1)'(1);
  localparam logic [WCNT_W-1:0] TIMEOUT_LAST = WCNT_W'(TIMEOUT - 1);

  req_state_e        state, state_nxt;
  logic [VW-1:0]     cand_buf     [NUM_CAND];
  logic [15:0]       cand_mag_buf [NUM_CAND];
  logic [VW-1:0]     q_vec;
  logic [15:0]       q_mag;
  logic [IDX_W:0]    num_cand;
  logic [IDX_W:0]    req_n_clamp;
  logic [IDX_W-1:0]  cur;
  logic [WCNT_W-1:0] wait_cnt;
  fp16_t             sim_q;
  fp16_t             best_sim;
  logic [IDX_W-1:0]  best_idx;
  logic              best_valid;
  logic              timeout_flag;
  logic              accept;
  logic              sim_gt;
  logic              sim_nan;
  logic              take_sim;
  logic              last_cand;
  logic              in_job;
  logic              in_resp;

  fp16_gt u_cmp (
    .a     (sim_q),
    .b     (best_sim),
    .gt    (sim_gt),
    .a_nan (sim_nan)
  );

  assign accept      = req_valid && (state == ST_IDLE);
  assign req_n_clamp = (req_num_cand > NUM_CAND_C) ? NUM_CAND_C : req_num_cand;
  assign last_cand   = ({1'b0, cur} == (num_cand - ONE_N));
  assign take_sim    = !sim_nan && (!best_valid || sim_gt);
  assign in_job      = (state == ST_ISSUE) || (state == ST_WAIT) || (state == ST_UPDATE);
  assign in_resp     = (state == ST_RESP);

  // Candidate buffer is only writable while idle so a scan always sees a frozen buffer.
  always_ff @(posedge clk) begin
    if (cand_we && (state == ST_IDLE)) begin
      cand_buf[cand_idx]     <= cand_vec;
      cand_mag_buf[cand_idx] <= cand_mag_inv;
    end
  end

  // State register; reset abandons any outstanding job.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic for the issue/wait/update scan loop.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = (req_n_clamp == '0) ? ST_RESP : ST_ISSUE;
      ST_ISSUE:  state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (cs_done)                        state_nxt = ST_UPDATE;
        else if (wait_cnt == TIMEOUT_LAST)  state_nxt = ST_RESP;
      end
      ST_UPDATE: state_nxt = last_cand ? ST_RESP : ST_ISSUE;
      ST_RESP:   if (res_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Scan datapath: request capture, wait counting, result capture and best tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_vec        <= '0;
      q_mag        <= '0;
      num_cand     <= '0;
      cur          <= '0;
      wait_cnt     <= '0;
      sim_q        <= FP16_ZERO;
      best_sim     <= FP16_ZERO;
      best_idx     <= '0;
      best_valid   <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            q_vec        <= req_vec;
            q_mag        <= req_mag_inv;
            num_cand     <= req_n_clamp;
            cur          <= '0;
            best_valid   <= 1'b0;
            best_idx     <= '0;
            best_sim     <= FP16_ZERO;
            timeout_flag <= 1'b0;
          end
        end
        ST_ISSUE: wait_cnt <= '0;
        ST_WAIT: begin
          if (cs_done)                       sim_q        <= cs_similarity;
          else if (wait_cnt == TIMEOUT_LAST) timeout_flag <= 1'b1;
          else                               wait_cnt     <= wait_cnt + WCNT_W'(1);
        end
        ST_UPDATE: begin
          if (take_sim) begin
            best_valid <= 1'b1;
            best_idx   <= cur;
            best_sim   <= sim_q;
          end
          if (!last_cand) cur <= cur + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign req_ready       = (state == ST_IDLE);
  assign busy            = (state != ST_IDLE);
  assign cs_start        = (state == ST_ISSUE);
  assign cs_vec1         = q_vec;
  assign cs_vec1_mag_inv = q_mag;
  assign cs_vec2         = in_job ? cand_buf[cur] : '0;
  assign cs_vec2_mag_inv = in_job ? cand_mag_buf[cur] : '0;
  assign res_valid       = in_resp;
  assign res_best_idx    = in_resp ? best_idx : '0;
  assign res_best_sim    = in_resp ? best_sim : FP16_ZERO;
  assign res_none        = in_resp && !best_valid;
  assign res_timeout     = in_resp && timeout_flag;

endmodule

// File: tb/tb_cosine_sim_requester.sv
// Self-checking bench: mock similarity unit plus a real-valued reference model of the best-match search.
module tb_cosine_sim_requester;
  import cossim_pkg::*;

  localparam int NC  = 8;
  localparam int IW  = 3;
  localparam int VL  = 32;
  localparam int VW  = 16 * VL;
  localparam int LAT = 34;

  logic          clk, rst;
  logic          cand_we;
  logic [IW-1:0] cand_idx;
  logic [VW-1:0] cand_vec;
  logic [15:0]   cand_mag_inv;
  logic          req_valid, req_ready;
  logic [VW-1:0] req_vec;
  logic [15:0]   req_mag_inv;
  logic [IW:0]   req_num_cand;
  logic          cs_start, cs_done;
  logic [VW-1:0] cs_vec1, cs_vec2;
  logic [15:0]   cs_vec1_mag_inv, cs_vec2_mag_inv, cs_similarity;
  logic          res_valid, res_ready;
  logic [IW-1:0] res_best_idx;
  logic [15:0]   res_best_sim;
  logic          res_none, res_timeout, busy;

  cosine_sim_requester #(.VEC_LEN(VL), .NUM_CAND(NC), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .cand_we(cand_we), .cand_idx(cand_idx), .cand_vec(cand_vec), .cand_mag_inv(cand_mag_inv),
    .req_valid(req_valid), .req_ready(req_ready), .req_vec(req_vec),
    .req_mag_inv(req_mag_inv), .req_num_cand(req_num_cand),
    .cs_start(cs_start), .cs_done(cs_done), .cs_vec1(cs_vec1), .cs_vec2(cs_vec2),
    .cs_vec1_mag_inv(cs_vec1_mag_inv), .cs_vec2_mag_inv(cs_vec2_mag_inv),
    .cs_similarity(cs_similarity),
    .res_valid(res_valid), .res_ready(res_ready), .res_best_idx(res_best_idx),
    .res_best_sim(res_best_sim), .res_none(res_none), .res_timeout(res_timeout),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [VW-1:0] tb_buf [NC];
  logic [15:0]   tb_mag [NC];
  logic [VW-1:0] cur_query;
  logic [15:0]   cur_qmag;
  logic [15:0]   mock_tbl [NC];
  int            mock_drop = 99;
  bit            mock_kill = 0;
  bit            mock_spurious = 0;
  int            start_count = 0;
  int            start_base = 0;
  int            vec_err = 0, stab_err = 0, wide_err = 0;

  bit            mock_pending = 0;
  int            mock_cnt = 0;
  int            mock_job = 0;
  bit            prev_start = 0;
  logic [VW-1:0] m_v1, m_v2;
  logic [15:0]   m_m1, m_m2;

  int            exp_idx, exp_jobs;
  logic [15:0]   exp_sim;
  bit            exp_none, exp_to;
  bit            got;

  // Mock similarity unit: fixed-latency done with a table-driven result, plus protocol watchdogs.
  always @(negedge clk) begin
    cs_done       = 1'b0;
    cs_similarity = 16'h0000;
    if (mock_kill || rst) begin
      mock_pending = 0;
    end else begin
      if (mock_pending) begin
        if (cs_vec1 !== m_v1 || cs_vec2 !== m_v2 || cs_vec1_mag_inv !== m_m1 || cs_vec2_mag_inv !== m_m2)
          stab_err++;
        mock_cnt--;
        if (mock_cnt == 0) begin
          mock_pending = 0;
          if (mock_job != mock_drop) begin
            cs_done       = 1'b1;
            cs_similarity = mock_tbl[mock_job];
          end
        end
      end
      if (cs_start) begin
        if (prev_start) wide_err++;
        mock_job = start_count - start_base;
        if (mock_job < NC) begin
          if (cs_vec2 !== tb_buf[mock_job] || cs_vec2_mag_inv !== tb_mag[mock_job] ||
              cs_vec1 !== cur_query || cs_vec1_mag_inv !== cur_qmag)
            vec_err++;
        end else begin
          vec_err++;
        end
        m_v1 = cs_vec1; m_v2 = cs_vec2; m_m1 = cs_vec1_mag_inv; m_m2 = cs_vec2_mag_inv;
        mock_pending = 1;
        mock_cnt     = LAT;
        start_count++;
      end
    end
    if (mock_spurious) cs_done = 1'b1;
    prev_start = cs_start;
  end

  function automatic fp16_vec_t rand_vec();
    fp16_vec_t v;
    for (int i = 0; i < VL; i++) v[i] = 16'($urandom);
    return v;
  endfunction

  function automatic bit is_nan(input logic [15:0] h);
    return (h[14:10] == 5'h1F) && (h[9:0] != 0);
  endfunction

  // Value of an FP16 pattern as a real; infinities become a large finite magnitude.
  function automatic real fp16_to_real(input logic [15:0] h);
    real m, s;
    int  e;
    e = int'(h[14:10]);
    s = h[15] ? -1.0 : 1.0;
    if (e == 31) return s * 1.0e9;
    if (e == 0) begin
      m = real'(h[9:0]);
      e = -24;
    end else begin
      m = real'(h[9:0]) + 1024.0;
      e = e - 25;
    end
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return s * m;
  endfunction

  // Reference: maximum non-NaN value over the scanned prefix, first occurrence wins.
  task automatic computeExpected(input int num);
    int  n, lim;
    bit  have;
    n        = (num > NC) ? NC : num;
    exp_to   = (mock_drop < n);
    lim      = exp_to ? mock_drop : n;
    exp_jobs = exp_to ? mock_drop + 1 : n;
    have     = 0;
    exp_idx  = 0;
    exp_sim  = 16'h0000;
    for (int i = 0; i < lim; i++) begin
      if (!is_nan(mock_tbl[i])) begin
        if (!have || fp16_to_real(mock_tbl[i]) > fp16_to_real(exp_sim)) begin
          have    = 1;
          exp_idx = i;
          exp_sim = mock_tbl[i];
        end
      end
    end
    exp_none = !have;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic writeCand(input int idx);
    @(negedge clk);
    cand_we      = 1'b1;
    cand_idx     = IW'(idx);
    cand_vec     = rand_vec();
    cand_mag_inv = 16'($urandom);
    tb_buf[idx]  = cand_vec;
    tb_mag[idx]  = cand_mag_inv;
    @(negedge clk);
    cand_we = 1'b0;
  endtask

  // Presents one request for its accept cycle, optionally with a same-cycle buffer write.
  task automatic applyStimulus(input int num, input bit wr_same);
    int w;
    @(negedge clk);
    checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
    start_base   = start_count;
    req_vec      = rand_vec();
    req_mag_inv  = 16'($urandom);
    cur_query    = req_vec;
    cur_qmag     = req_mag_inv;
    req_num_cand = (IW+1)'(num);
    req_valid    = 1'b1;
    if (wr_same) begin
      w            = $urandom_range(0, NC-1);
      cand_we      = 1'b1;
      cand_idx     = IW'(w);
      cand_vec     = rand_vec();
      cand_mag_inv = 16'($urandom);
      tb_buf[w]    = cand_vec;
      tb_mag[w]    = cand_mag_inv;
    end
    @(negedge clk);
    req_valid = 1'b0;
    cand_we   = 1'b0;
  endtask

  task automatic waitResult();
    got = 0;
    for (int i = 0; i < 3000; i++) begin
      if (res_valid) begin got = 1; break; end
      @(negedge clk);
    end
    checkOutput("res_valid_seen", 32'(got), 32'd1);
  endtask

  // Checks the presented result against the model, holds it for a while, then retires it.
  task automatic collectResult(input string tag, input int hold);
    if (got) begin
      checkOutput({tag, "_idx"},  32'(res_best_idx), 32'(exp_idx));
      checkOutput({tag, "_sim"},  32'(res_best_sim), 32'(exp_sim));
      checkOutput({tag, "_none"}, 32'(res_none), 32'(exp_none));
      checkOutput({tag, "_to"},   32'(res_timeout), 32'(exp_to));
      checkOutput({tag, "_jobs"}, 32'(start_count - start_base), 32'(exp_jobs));
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        checkOutput({tag, "_hold_valid"}, 32'(res_valid), 32'd1);
        checkOutput({tag, "_hold_idx"},   32'(res_best_idx), 32'(exp_idx));
        checkOutput({tag, "_hold_sim"},   32'(res_best_sim), 32'(exp_sim));
        checkOutput({tag, "_hold_none"},  32'(res_none), 32'(exp_none));
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      checkOutput({tag, "_post_valid"}, 32'(res_valid), 32'd0);
      checkOutput({tag, "_post_ready"}, 32'(req_ready), 32'd1);
      checkOutput({tag, "_post_flags"}, 32'({res_none, res_timeout}), 32'd0);
    end
  endtask

  task automatic runRequest(input string tag, input int num, input bit wr_same, input int hold);
    computeExpected(num);
    applyStimulus(num, wr_same);
    waitResult();
    collectResult(tag, hold);
  endtask

  initial begin
    rst = 1'b1; cand_we = 0; cand_idx = 0; cand_vec = 0; cand_mag_inv = 0;
    req_valid = 0; req_vec = 0; req_mag_inv = 0; req_num_cand = 0; res_ready = 0;
    for (int i = 0; i < NC; i++) mock_tbl[i] = FP16_ZERO;
    repeat (2) @(negedge clk);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_busy",      32'(busy), 32'd0);
    checkOutput("rst_outs",      32'({cs_start, res_valid, res_none, res_timeout}), 32'd0);
    checkOutput("rst_res",       32'({res_best_idx, res_best_sim}), 32'd0);
    checkOutput("rst_vec",       32'((cs_vec1 == '0) && (cs_vec2 == '0)), 32'd1);
    rst = 1'b0;

    for (int i = 0; i < NC; i++) writeCand(i);

    $display("[TB] directed: max in the middle");
    mock_tbl[0] = 16'h3800; mock_tbl[1] = FP16_ONE; mock_tbl[2] = 16'h3A00;
    runRequest("best_mid", 3, 0, 0);

    $display("[TB] directed: tie keeps lower index");
    mock_tbl[0] = FP16_NEG_ONE; mock_tbl[1] = FP16_NEG_ONE;
    runRequest("tie", 2, 0, 0);

    $display("[TB] directed: empty request");
    computeExpected(0);
    applyStimulus(0, 0);
    checkOutput("n0_valid_next", 32'(res_valid), 32'd1);
    waitResult();
    collectResult("n0", 0);

    $display("[TB] directed: all NaN");
    for (int i = 0; i < 4; i++) mock_tbl[i] = FP16_QNAN;
    runRequest("all_nan", 4, 0, 0);

    $display("[TB] directed: timeout on candidate 1");
    mock_tbl[0] = 16'h3400; mock_drop = 1;
    runRequest("timeout", 3, 0, 0);
    mock_drop = 99;

    $display("[TB] directed: reset in WAIT");
    applyStimulus(3, 0);
    for (int i = 0; i < 200 && start_count == start_base; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    checkOutput("rst_mid_busy_pre", 32'(busy), 32'd1);
    mock_kill = 1;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_mid_start", 32'(cs_start), 32'd0);
    checkOutput("rst_mid_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_mid_busy",  32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mock_kill = 0;
    mock_spurious = 1;
    @(negedge clk);
    mock_spurious = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("spurious_no_valid", 32'({res_valid, busy}), 32'd0);
    end

    $display("[TB] directed: result held while not ready");
    for (int i = 0; i < NC; i++) mock_tbl[i] = 16'($urandom);
    runRequest("hold", 4, 0, 5);

    $display("[TB] directed: candidate write while busy is dropped");
    computeExpected(2);
    applyStimulus(2, 0);
    repeat (5) @(negedge clk);
    cand_we = 1'b1; cand_idx = '0; cand_vec = rand_vec(); cand_mag_inv = 16'($urandom);
    @(negedge clk);
    cand_we = 1'b0;
    waitResult();
    collectResult("busy_we", 0);
    runRequest("after_we", 2, 0, 0);

    $display("[TB] directed: N clamped to buffer depth");
    for (int i = 0; i < NC; i++) mock_tbl[i] = 16'($urandom);
    runRequest("clamp", 15, 0, 0);

    $display("[TB] random requests");
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < NC; i++) begin
        case ($urandom_range(0, 5))
          0:       mock_tbl[i] = FP16_QNAN;
          1:       mock_tbl[i] = (i > 0) ? mock_tbl[i-1] : FP16_ZERO;
          2:       mock_tbl[i] = 16'h8000;
          default: mock_tbl[i] = 16'($urandom);
        endcase
      end
      runRequest("rand", $urandom_range(0, 10), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    checkOutput("vec_content", 32'(vec_err), 32'd0);
    checkOutput("vec_stable",  32'(stab_err), 32'd0);
    checkOutput("start_width", 32'(wide_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
